fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one-word reads to instruction memory,
// buffers responses in a small prefetch queue and hands words to the consumer
// in order. Handles branch redirects and stops fetching after a halt word.
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [3:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [3:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [3:0]  redirect_pc,
  output logic        halted
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] HALT_OP = 4'h9;

  logic [3:0]    r_fetch_pc;
  logic [3:0]    r_req_pc;
  logic          r_in_flight;
  logic          r_halt_seen;
  logic          r_halted;
  logic [CW-1:0] r_count;
  logic [15:0]   r_word [DEPTH];
  logic [3:0]    r_pc   [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic          w_halt_pop;
  logic [CW:0]   w_occ_after;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_wr_idx;
  logic [15:0]   w_word_nxt [DEPTH];
  logic [3:0]    w_pc_nxt   [DEPTH];

  // Head is entry 0 of a shift queue; outputs come straight from registers,
  // so instr_ready never reaches instr_valid combinationally.
  assign instr_valid = (r_count != '0) && !r_halted && !rst;
  assign instr       = instr_valid ? r_word[0] : 16'h0000;
  assign instr_pc    = instr_valid ? r_pc[0]   : 4'h0;
  assign halted      = r_halted && !rst;

  assign w_pop      = instr_valid && instr_ready;
  // A response returning after the halt word was queued is dropped.
  assign w_push     = r_in_flight && !r_halt_seen;
  assign w_halt_pop = w_pop && (r_word[0][15:12] == HALT_OP);

  // Only request when the response is guaranteed a free slot next cycle.
  assign w_occ_after = (CW+1)'(r_count) + (CW+1)'(r_in_flight) - (CW+1)'(w_pop);
  assign w_issue     = !rst && !redirect && !r_halt_seen && !r_halted &&
                       (w_occ_after < (CW+1)'(DEPTH));
  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;

  // Next queue contents: shift on pop, then write the response behind the survivors.
  always_comb begin
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_wr_idx    = r_count - CW'(w_pop);
    for (int i = 0; i < DEPTH; i++) begin
      w_word_nxt[i] = r_word[i];
      w_pc_nxt[i]   = r_pc[i];
    end
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_word_nxt[i] = r_word[i+1];
        w_pc_nxt[i]   = r_pc[i+1];
      end
    end
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_idx == CW'(i)) begin
          w_word_nxt[i] = imem_data;
          w_pc_nxt[i]   = r_req_pc;
        end
      end
    end
  end

  // State update: reset, then sticky halt, then redirect, then normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc  <= 4'h0;
      r_req_pc    <= 4'h0;
      r_in_flight <= 1'b0;
      r_halt_seen <= 1'b0;
      r_halted    <= 1'b0;
      r_count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= 16'h0000;
        r_pc[i]   <= 4'h0;
      end
    end else if (r_halted) begin
      r_in_flight <= 1'b0;
    end else if (redirect) begin
      r_count     <= '0;
      r_in_flight <= 1'b0;
      r_halt_seen <= 1'b0;
      r_fetch_pc  <= redirect_pc;
    end else begin
      r_count     <= w_count_nxt;
      r_in_flight <= w_issue;
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= w_word_nxt[i];
        r_pc[i]   <= w_pc_nxt[i];
      end
      if (w_issue) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 4'h1;
      end
      if (w_push && (imem_data[15:12] == HALT_OP))
        r_halt_seen <= 1'b1;
      if (w_halt_pop)
        r_halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [3:0]  redirect_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [15:0] mem [16];
  logic [3:0]  mem_q;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory returns the word for last cycle's address.
  always @(posedge clk) mem_q <= imem_addr;
  assign imem_data = mem[mem_q];

  // Reference model: a queue of {word, pc} plus fetch state.
  typedef logic [19:0] ent_t;
  ent_t       m_q[$];
  logic [3:0] m_fpc = 4'h0;
  logic [3:0] m_ifpc = 4'h0;
  bit         m_inflight = 1'b0;
  bit         m_hs = 1'b0;
  bit         m_halted = 1'b0;

  function automatic bit exp_valid();
    return (m_q.size() != 0) && !m_halted && !rst;
  endfunction

  function automatic bit exp_pop();
    return exp_valid() && instr_ready;
  endfunction

  function automatic bit exp_req();
    int occ;
    occ = m_q.size() + int'(m_inflight) - int'(exp_pop());
    return !rst && !redirect && !m_hs && !m_halted && (occ < DEPTH);
  endfunction

  function automatic logic [15:0] exp_instr();
    return exp_valid() ? m_q[0][19:4] : 16'h0000;
  endfunction

  function automatic logic [3:0] exp_pc();
    return exp_valid() ? m_q[0][3:0] : 4'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model advance on each rising edge, using the inputs of the cycle just ended.
  always @(posedge clk) begin
    bit p, rq, hp;
    logic [15:0] w;
    p  = exp_pop();
    rq = exp_req();
    hp = 1'b0;
    if (rst) begin
      m_q.delete();
      m_fpc = 4'h0; m_inflight = 1'b0; m_hs = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_inflight = 1'b0;
    end else if (redirect) begin
      m_q.delete();
      m_inflight = 1'b0; m_hs = 1'b0; m_fpc = redirect_pc;
    end else begin
      if (p) begin
        hp = (m_q[0][19:16] == 4'h9);
        void'(m_q.pop_front());
      end
      if (m_inflight && !m_hs) begin
        w = mem[m_ifpc];
        m_q.push_back({w, m_ifpc});
        if (w[15:12] == 4'h9) m_hs = 1'b1;
      end
      m_inflight = rq;
      if (rq) begin
        m_ifpc = m_fpc;
        m_fpc  = m_fpc + 4'h1;
      end
      if (hp) m_halted = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req", imem_req, exp_req());
      if (exp_req()) chk("addr", imem_addr, m_fpc);
      chk("valid", instr_valid, exp_valid());
      chk("instr", instr, exp_instr());
      chk("instr_pc", instr_pc, exp_pc());
      chk("halted", halted, m_halted && !rst);
      chk("fifo_overflow", dut.r_count > DEPTH, 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic stream_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 | 16'(i);
  endtask

  initial begin
    int nxt;
    int got_pcs[$];
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 4'h0;
    stream_mem();
    cyc();
    cmp_en = 1'b1;
    cyc();

    // Reset state
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", instr_pc, 0);
    cyc();

    // Streaming: first valid 2 cycles after release, then one per cycle with wrap
    rst = 1'b0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      chk("stream_valid", instr_valid, k >= 2);
      chk("stream_addr", imem_addr, (k & 15));
      if (k >= 2) begin
        chk("stream_pc", instr_pc, ((k - 2) & 15));
        chk("stream_instr", instr, 32'h1000 | ((k - 2) & 15));
      end
      cyc();
    end

    // Backpressure: queue fills to DEPTH, fetch stops, head held
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        chk("bp_noreq", imem_req, 0);
        chk("bp_valid", instr_valid, 1);
        chk("bp_head", instr_pc, 0);
        chk("bp_occ", dut.r_count, DEPTH);
      end
      cyc();
    end
    instr_ready = 1'b1;
    nxt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        chk("bp_seq", instr_pc, nxt & 15);
        nxt++;
      end
      cyc();
    end
    chk("bp_count", nxt, 10);

    // Redirect with two words queued
    do_reset();
    for (int k = 0; k < 10; k++) begin
      redirect    = (k == 4);
      redirect_pc = 4'hA;
      instr_ready = (k >= 5);
      @(negedge clk);
      if (k == 4) begin
        chk("redir_noreq", imem_req, 0);
        chk("redir_queued", dut.r_count, 2);
      end
      if (k == 5) begin
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 4'hA);
      end
      if (k == 5 || k == 6) chk("redir_gap", instr_valid, 0);
      if (k == 7) begin
        chk("redir_first_valid", instr_valid, 1);
        chk("redir_first_pc", instr_pc, 4'hA);
      end
      if (k == 8) chk("redir_second_pc", instr_pc, 4'hB);
      cyc();
    end
    redirect = 1'b0;

    // Halt word at address 3
    stream_mem();
    mem[3] = 16'h9000;
    instr_ready = 1'b1;
    do_reset();
    got_pcs.delete();
    for (int k = 0; k < 12; k++) begin
      redirect    = (k == 7 || k == 8);
      redirect_pc = 4'h2;
      @(negedge clk);
      chk("halt_no_addr5", imem_req && (imem_addr == 4'h5), 0);
      chk("halt_flag", halted, k >= 6);
      if (k == 5) chk("halt_word", instr, 16'h9000);
      if (k >= 6) chk("halt_noreq", imem_req, 0);
      if (instr_valid) got_pcs.push_back(int'(instr_pc));
      cyc();
    end
    redirect = 1'b0;
    chk("halt_ndeliv", got_pcs.size(), 4);
    for (int i = 0; i < got_pcs.size() && i < 4; i++) chk("halt_deliv_pc", got_pcs[i], i);

    // Reset mid-stream with a response in flight
    stream_mem();
    do_reset();
    for (int k = 0; k < 5; k++) cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_inflight", dut.r_in_flight, 1);
    chk("midrst_req", imem_req, 0);
    chk("midrst_valid", instr_valid, 0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst_v", instr_valid, k >= 2);
      if (k >= 2) chk("midrst_pc", instr_pc, k - 2);
      cyc();
    end

    // Redirect to 4'hF colliding with a pop
    do_reset();
    for (int k = 0; k < 11; k++) begin
      redirect    = (k == 4);
      redirect_pc = 4'hF;
      @(negedge clk);
      if (k == 4) begin
        chk("wrap_pop_valid", instr_valid, 1);
        chk("wrap_pop_pc", instr_pc, 2);
      end
      if (k == 5) chk("wrap_addr", imem_addr, 4'hF);
      if (k == 5 || k == 6) chk("wrap_gap", instr_valid, 0);
      if (k == 7) chk("wrap_pc0", instr_pc, 4'hF);
      if (k == 8) chk("wrap_pc1", instr_pc, 4'h0);
      if (k == 9) chk("wrap_pc2", instr_pc, 4'h1);
      if (k >= 7 && k <= 9) chk("wrap_valid", instr_valid, 1);
      cyc();
    end
    redirect = 1'b0;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 4'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 15)] = 16'($urandom);
      cyc();
    end
    rst = 1'b0; redirect = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
